ibex_regfile_wiper: RTL
=======================

Name: ibex_regfile_wiper

Overview:
- Write-side initiator for the FPGA register file: on request, sequences writes of WordZeroVal to every architectural GPR (x1..x(NUM_WORDS-1)) through the single write port.
- Sits between ID/WB writeback and the register file write port. Passes core writes through when idle and stalls the core while wiping.
- Used on privilege or context switch so no stale data remains in any physical register, including the renamed/idle slot.

Parameters:
- RV32E, 0, selects 16 architectural registers instead of 32; sets NUM_WORDS = 2**(RV32E ? 4 : 5).
- DataWidth, 32, register data width.
- WordZeroVal, '0, value written to each register.
- Passes, 2, number of full write sweeps. 2 guarantees the renaming idle slot is also overwritten. Legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wipe_req_i  in  1  single-cycle wipe request
- wipe_busy_o  out  1  wipe in progress
- wipe_done_o  out  1  one-cycle pulse when the wipe completes
- core_waddr_i  in  5  core write address
- core_wdata_i  in  DataWidth  core write data
- core_we_i  in  1  core write enable
- core_stall_o  out  1  core must hold its write
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data
- rf_we_o  out  1  register file write enable
- rf_raddr_o  out  5  verify read address (verify feature only; otherwise 0)
- rf_rdata_i  in  DataWidth  verify read data (async read)
- err_o  out  1  sticky verify mismatch flag

Behaviour:
- Reset: state IDLE, addr counter = 1, pass counter = 0. Outputs wipe_busy_o, wipe_done_o, core_stall_o, err_o, rf_we_o = 0; rf_raddr_o = 0.
- Reset asserted mid-wipe aborts immediately to IDLE. No done pulse; err_o clears.
- IDLE:
  - rf_* mirror core_* combinationally (zero added latency); core_stall_o = 0.
  - wipe_req_i = 1 moves to WIPE next cycle.
  - A core write in the same cycle as wipe_req_i still completes.
- WIPE:
  - Each cycle: rf_we_o = 1, rf_waddr_o = addr, rf_wdata_o = WordZeroVal.
  - addr increments 1..NUM_WORDS-1. On reaching NUM_WORDS-1 it wraps to 1 and the pass counter increments.
  - After the last write of pass Passes-1: go to VERIFY if enabled, else DONE.
  - wipe_busy_o = core_stall_o = 1. Core inputs are ignored, not dropped: the core holds them under stall.
- DONE: wipe_done_o = 1 for one cycle, stall still asserted, then IDLE.
- Latency (RV32E = 0, Passes = 2, no verify): request at cycle 0; writes on cycles 1..62; done pulse on cycle 63; core unstalled on cycle 64.
- wipe_req_i while busy is ignored. It is neither queued nor restarts the wipe.
- The address counter never produces 0. Counter width is 5 bits; upper bit forced 0 when RV32E.

Optional Feature:
- Macro: IBEX_WIPE_VERIFY_EN.
- Defined:
  - A VERIFY state follows the last pass. It steps rf_raddr_o through 1..NUM_WORDS-1, one per cycle, with rf_we_o = 0.
  - Any rf_rdata_i != WordZeroVal sets err_o. err_o is sticky until the next accepted wipe_req_i or reset.
  - DONE follows the last read, which adds NUM_WORDS-1 cycles.
- Undefined: no VERIFY state; rf_raddr_o tied 0, err_o tied 0, rf_rdata_i unused.

Decomposition:
- Package ibex_wipe_pkg holds:
  - wipe_state_e enum: IDLE, WIPE, VERIFY, DONE.
  - localparam MaxPasses = 4.
  - function num_words(RV32E).
- Sub-module: none required. The address/pass counter stays inline; it is too small to justify a separate module.

Test Plan:
- Idle pass-through: core_we_i = 1, waddr = 5, wdata = 0xDEADBEEF -> same cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xDEADBEEF; core_stall_o = 0.
- Full wipe (Passes = 2): preload x1..x31 with 0xA5A5A5A5, pulse wipe_req_i -> 62 writes of 0, addresses 1..31 twice, never 0. wipe_done_o at cycle 63. Every physical register, including the idle slot, reads 0.
- Stall: core_we_i = 1 held during the wipe -> core_stall_o = 1 throughout, no core write reaches rf. The held write lands in the first cycle after DONE.
- Reset mid-wipe: deassert rst_ni at write 10 -> outputs at reset values asynchronously. A new request restarts at addr 1 with no done pulse from the aborted run.
- Verify (IBEX_WIPE_VERIFY_EN): force rf_rdata_i = 1 when rf_raddr_o = 7 -> err_o rises the next cycle and stays high until the next wipe_req_i.
- RV32E = 1, Passes = 1: addresses 1..15 only, done at cycle 16.

Source files
------------

// File: rtl/ibex_wipe_pkg.sv
// Shared types and helpers for the register file wiper.
package ibex_wipe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WIPE,
        VERIFY,
        DONE
    } wipe_state_e;

    localparam int MaxPasses = 4;

    function automatic int num_words(input bit rv32e);
        return rv32e ? 16 : 32;
    endfunction

endpackage

// File: rtl/ibex_regfile_wiper.sv
// Write-side wiper for the register file: sweeps WordZeroVal into x1..x(N-1) Passes times.
// Optional read-back check of every register is enabled with IBEX_WIPE_VERIFY_EN.
module ibex_regfile_wiper
    import ibex_wipe_pkg::*;
#(
    parameter bit                   RV32E       = 1'b0,
    parameter int                   DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    parameter int                   Passes      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wipe_req_i,
    output logic                 wipe_busy_o,
    output logic                 wipe_done_o,
    input  logic [4:0]           core_waddr_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    input  logic                 core_we_i,
    output logic                 core_stall_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic                 err_o
);

    localparam int               NumWords = num_words(RV32E);
    localparam logic [4:0]       LastAddr = 5'(NumWords - 1);
    localparam int               PassW    = $clog2(MaxPasses);
    localparam logic [PassW-1:0] LastPass = PassW'(Passes - 1);

    wipe_state_e      state_q;
    logic [4:0]       addr_q;
    logic [4:0]       addr_eff;
    logic [PassW-1:0] pass_q;
    logic             err_q;

    // Top address bit only exists for the 32-register file.
    assign addr_eff = RV32E ? {1'b0, addr_q[3:0]} : addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= 5'd1;
            pass_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wipe_req_i) begin
                        state_q <= WIPE;
                        addr_q  <= 5'd1;
                        pass_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                WIPE: begin
                    if (addr_q == LastAddr) begin
                        addr_q <= 5'd1;
                        if (pass_q == LastPass) begin
                            pass_q <= '0;
`ifdef IBEX_WIPE_VERIFY_EN
                            state_q <= VERIFY;
`else
                            state_q <= DONE;
`endif
                        end else begin
                            pass_q <= pass_q + PassW'(1);
                        end
                    end else begin
                        addr_q <= addr_q + 5'd1;
                    end
                end
`ifdef IBEX_WIPE_VERIFY_EN
                VERIFY: begin
                    if (rf_rdata_i != WordZeroVal) err_q <= 1'b1;
                    if (addr_q == LastAddr) begin
                        addr_q  <= 5'd1;
                        state_q <= DONE;
                    end else begin
                        addr_q <= addr_q + 5'd1;
                    end
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wipe_busy_o  = (state_q != IDLE);
    assign core_stall_o = (state_q != IDLE);
    assign wipe_done_o  = (state_q == DONE);
    assign err_o        = err_q;

`ifdef IBEX_WIPE_VERIFY_EN
    assign rf_raddr_o = (state_q == VERIFY) ? addr_eff : 5'd0;
`else
    logic unused_rdata;
    assign unused_rdata = ^rf_rdata_i;
    assign rf_raddr_o   = 5'd0;
`endif

    // Idle pass-through is gated by reset so the write port is quiet while held in reset.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = addr_eff;
        rf_wdata_o = WordZeroVal;
        if (state_q == IDLE) begin
            rf_we_o    = core_we_i & rst_ni;
            rf_waddr_o = core_waddr_i;
            rf_wdata_o = core_wdata_i;
        end else if (state_q == WIPE) begin
            rf_we_o = 1'b1;
        end
    end

endmodule
